// File: rtl/branch_ctrl_pkg.sv
// Shared types and stall-depth constants for the branch hazard controller.
package branch_ctrl_pkg;

   typedef enum logic {
      RUN,
      STALL
   } br_state_t;

   // Stall depth fits in two bits (0..2); the counter only ever holds depth-1.
   localparam int unsigned STALL_W = 2;

   localparam logic [1:0] STALL_EX_LOAD  = 2'd2;
   localparam logic [1:0] STALL_EX_ALU   = 2'd1;
   localparam logic [1:0] STALL_MEM_LOAD = 2'd1;
   localparam logic [1:0] STALL_NONE     = 2'd0;

   function automatic logic [1:0] max_stall(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/branch_dep_check.sv
// Combinational stall-depth calculation for a branch in ID against producers in EX and MEM.
module branch_dep_check
   import branch_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW = 5
) (
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              ex_regwrite,
   input  logic              ex_memread,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              mem_regwrite,
   input  logic              mem_memread,
   input  logic [REG_AW-1:0] mem_rd,
   output logic [1:0]        n_stall
);

   logic ex_live;
   logic mem_live;
   logic [1:0] need_rs1;
   logic [1:0] need_rs2;

   // x0 never carries a real dependency.
   assign ex_live  = ex_regwrite && (ex_rd != '0);
   assign mem_live = mem_regwrite && (mem_rd != '0);

   // EX is the younger producer, so its match takes priority over MEM.
   function automatic logic [1:0] src_need(input logic [REG_AW-1:0] rs,
                                           input logic ex_l, input logic ex_ld,
                                           input logic [REG_AW-1:0] ex_d,
                                           input logic mem_l, input logic mem_ld,
                                           input logic [REG_AW-1:0] mem_d);
      if (ex_l && (rs == ex_d)) begin
         return ex_ld ? STALL_EX_LOAD : STALL_EX_ALU;
      end else if (mem_l && (rs == mem_d) && mem_ld) begin
         return STALL_MEM_LOAD;
      end
      // An ALU result in MEM is forwarded straight into the ID comparator.
      return STALL_NONE;
   endfunction

   // Per-source requirement, then the worse of the two.
   always_comb begin
      need_rs1 = src_need(id_rs1, ex_live, ex_memread, ex_rd, mem_live, mem_memread, mem_rd);
      need_rs2 = src_need(id_rs2, ex_live, ex_memread, ex_rd, mem_live, mem_memread, mem_rd);
      n_stall  = max_stall(need_rs1, need_rs2);
   end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Decode-stage branch sequencer: stalls on unresolved operands, then resolves via id_eq.
module branch_hazard_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic              id_branch,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_eq,
   input  logic              ex_regwrite,
   input  logic              ex_memread,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              mem_regwrite,
   input  logic              mem_memread,
   input  logic [REG_AW-1:0] mem_rd,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              id_bubble,
   output logic              pc_src,
   output logic              if_flush,
   output logic [CNT_W-1:0]  br_count,
   output logic [CNT_W-1:0]  br_taken,
   output logic [CNT_W-1:0]  br_stall
);

   br_state_t          state_q, state_d;
   logic [STALL_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0]   br_count_q, br_taken_q, br_stall_q;
   logic [1:0]         n_stall;
   logic               branch_active;
   logic               resolve;
   logic               taken;

   branch_dep_check #(
      .REG_AW (REG_AW)
   ) u_dep_check (
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .ex_regwrite  (ex_regwrite),
      .ex_memread   (ex_memread),
      .ex_rd        (ex_rd),
      .mem_regwrite (mem_regwrite),
      .mem_memread  (mem_memread),
      .mem_rd       (mem_rd),
      .n_stall      (n_stall)
   );

   assign branch_active = id_valid && id_branch;

   // Next-state and pipeline control; reset forces the pass-through defaults.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      id_bubble  = 1'b0;
      pc_src     = 1'b1;
      if_flush   = 1'b0;
      resolve    = 1'b0;
      taken      = 1'b0;
      if (!rst) begin
         unique case (state_q)
            RUN: begin
               if (branch_active) begin
                  if (n_stall != 2'd0) begin
                     pc_write   = 1'b0;
                     ifid_write = 1'b0;
                     id_bubble  = 1'b1;
                     cnt_d      = n_stall - 2'd1;
                     state_d    = (n_stall == STALL_EX_LOAD) ? STALL : RUN;
                  end else begin
                     resolve = 1'b1;
                     taken   = id_eq;
                     if (id_eq) begin
                        pc_src   = 1'b0;
                        if_flush = 1'b1;
                     end
                  end
               end
            end
            STALL: begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               id_bubble  = 1'b1;
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - 2'd1;
               end
               // Leave once the decremented count reaches zero.
               if (cnt_q <= 2'd1) begin
                  state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   // FSM state, stall counter and saturating performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         cnt_q      <= '0;
         br_count_q <= '0;
         br_taken_q <= '0;
         br_stall_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (resolve && !(&br_count_q)) begin
            br_count_q <= br_count_q + CNT_W'(1);
         end
         if (taken && !(&br_taken_q)) begin
            br_taken_q <= br_taken_q + CNT_W'(1);
         end
         if (!pc_write && !(&br_stall_q)) begin
            br_stall_q <= br_stall_q + CNT_W'(1);
         end
      end
   end

   assign br_count = br_count_q;
   assign br_taken = br_taken_q;
   assign br_stall = br_stall_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
module tb_branch_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_branch, id_eq;
   logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
   logic       ex_regwrite, ex_memread, mem_regwrite, mem_memread;
   logic       pc_write, ifid_write, id_bubble, pc_src, if_flush;
   logic [31:0] br_count, br_taken, br_stall;
   logic       s_pc_write, s_ifid_write, s_id_bubble, s_pc_src, s_if_flush;
   logic [1:0] s_count, s_taken, s_stall;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_hazard_ctrl #(.CNT_W(32), .REG_AW(5)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_branch(id_branch),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_eq(id_eq),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
      .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
      .pc_write(pc_write), .ifid_write(ifid_write), .id_bubble(id_bubble),
      .pc_src(pc_src), .if_flush(if_flush),
      .br_count(br_count), .br_taken(br_taken), .br_stall(br_stall)
   );

   // Narrow-counter copy on the same stimulus exercises saturation.
   branch_hazard_ctrl #(.CNT_W(2), .REG_AW(5)) dut_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_branch(id_branch),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_eq(id_eq),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
      .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
      .pc_write(s_pc_write), .ifid_write(s_ifid_write), .id_bubble(s_id_bubble),
      .pc_src(s_pc_src), .if_flush(s_if_flush),
      .br_count(s_count), .br_taken(s_taken), .br_stall(s_stall)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_producers();
      ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
      mem_regwrite = 0; mem_memread = 0; mem_rd = 0;
   endtask

   task automatic branch(input logic [4:0] rs1, input logic [4:0] rs2, input logic eq);
      id_valid = 1; id_branch = 1; id_rs1 = rs1; id_rs2 = rs2; id_eq = eq;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic ctl(input string tag, input logic pw, input logic bub,
                      input logic src, input logic fl);
      chk({tag, "_pc_write"}, pc_write, pw);
      chk({tag, "_ifid_write"}, ifid_write, pw);
      chk({tag, "_id_bubble"}, id_bubble, bub);
      chk({tag, "_pc_src"}, pc_src, src);
      chk({tag, "_if_flush"}, if_flush, fl);
   endtask

   task automatic cnts(input string tag, input int c, input int t, input int s);
      chk({tag, "_br_count"}, br_count, c);
      chk({tag, "_br_taken"}, br_taken, t);
      chk({tag, "_br_stall"}, br_stall, s);
   endtask

   initial begin
      rst = 1;
      clear_producers();
      branch(5'd5, 5'd6, 1'b1);
      // Reset held with a live taken branch: outputs stay at pass-through.
      repeat (2) @(posedge clk);
      @(negedge clk);
      ctl("rst", 1, 0, 1, 0);
      cnts("rst", 0, 0, 0);
      nxt();
      rst = 0;

      // Taken branch, no producers: resolves immediately.
      branch(5'd5, 5'd6, 1'b1);
      @(negedge clk); ctl("taken", 1, 0, 0, 1);
      nxt(); cnts("taken", 1, 1, 0);

      // Flushed slot behind the taken branch.
      id_valid = 0;
      @(negedge clk); ctl("flushed", 1, 0, 1, 0);
      nxt(); cnts("flushed", 1, 1, 0);

      // Load in EX feeding rs1: two stall cycles, id_eq ignored while stalled.
      branch(5'd5, 5'd6, 1'b1);
      ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd5;
      @(negedge clk); ctl("ld_s1", 0, 1, 1, 0);
      nxt(); cnts("ld_s1", 1, 1, 1);
      clear_producers();
      mem_regwrite = 1; mem_memread = 1; mem_rd = 5'd5;
      @(negedge clk); ctl("ld_s2", 0, 1, 1, 0);
      nxt(); cnts("ld_s2", 1, 1, 2);
      clear_producers();
      @(negedge clk); ctl("ld_res", 1, 0, 0, 1);
      nxt(); cnts("ld_res", 2, 2, 2);

      id_valid = 0;
      nxt();

      // ALU result in EX feeding rs2: one stall, then not-taken resolve.
      branch(5'd1, 5'd7, 1'b0);
      ex_regwrite = 1; ex_rd = 5'd7;
      @(negedge clk); ctl("alu_s1", 0, 1, 1, 0);
      nxt(); cnts("alu_s1", 2, 2, 3);
      clear_producers();
      mem_regwrite = 1; mem_rd = 5'd7;
      @(negedge clk); ctl("alu_res", 1, 0, 1, 0);
      nxt(); cnts("alu_res", 3, 2, 3);

      // rd == x0 is never a dependency.
      clear_producers();
      branch(5'd0, 5'd3, 1'b0);
      ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd0;
      @(negedge clk); ctl("x0", 1, 0, 1, 0);
      nxt(); cnts("x0", 4, 2, 3);
      chk("sat_count_4", s_count, 2'd3);

      // Hazardous operands but no live branch: nothing happens.
      clear_producers();
      branch(5'd5, 5'd6, 1'b1);
      id_valid = 0;
      ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd5;
      @(negedge clk); ctl("novalid", 1, 0, 1, 0);
      nxt(); cnts("novalid", 4, 2, 3);
      id_valid = 1; id_branch = 0;
      @(negedge clk); ctl("nobranch", 1, 0, 1, 0);
      nxt(); cnts("nobranch", 4, 2, 3);

      // Load in MEM feeding rs2: one stall.
      clear_producers();
      branch(5'd2, 5'd9, 1'b1);
      mem_regwrite = 1; mem_memread = 1; mem_rd = 5'd9;
      @(negedge clk); ctl("mld_s1", 0, 1, 1, 0);
      nxt(); cnts("mld_s1", 4, 2, 4);
      clear_producers();
      @(negedge clk); ctl("mld_res", 1, 0, 0, 1);
      nxt(); cnts("mld_res", 5, 3, 4);

      // Matching rd without regwrite is not a producer.
      id_valid = 0;
      nxt();
      branch(5'd5, 5'd6, 1'b0);
      ex_memread = 1; ex_rd = 5'd5;
      @(negedge clk); ctl("norw", 1, 0, 1, 0);
      nxt(); cnts("norw", 6, 3, 4);
      chk("sat_count", s_count, 2'd3);
      chk("sat_taken", s_taken, 2'd3);
      chk("sat_stall", s_stall, 2'd3);

      // Reset in the first load-use stall cycle.
      clear_producers();
      branch(5'd5, 5'd6, 1'b0);
      ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd5;
      @(negedge clk); ctl("rst_s1", 0, 1, 1, 0);
      rst = 1;
      nxt();
      rst = 0;
      clear_producers();
      id_valid = 0;
      cnts("rst_mid", 0, 0, 0);
      @(negedge clk); ctl("rst_after", 1, 0, 1, 0);
      nxt(); cnts("rst_after", 0, 0, 0);
      chk("rst_sat_count", s_count, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
- Decode-stage controller that sequences branch resolution in the 5-stage pipeline.
- Detects when a branch in ID depends on a producer still in EX or MEM, and stalls PC and IF/ID until operands are valid.
- Once operands are valid, drives pc_src/if_flush from the external equality comparator.
- Keeps saturating performance counters for branches, taken branches and branch stall cycles.

Parameters:
- CNT_W, 32, width of each performance counter
- REG_AW, 5, register address width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  IF/ID holds a live instruction; low after flush/bubble
- id_branch  in  1  decoded instruction is a branch (beq)
- id_rs1  in  REG_AW  branch source 1
- id_rs2  in  REG_AW  branch source 2
- id_eq  in  1  comparator result, read_data_1==read_data_2 after ID forwarding
- ex_regwrite  in  1  ID/EX instruction writes a register
- ex_memread  in  1  ID/EX instruction is a load
- ex_rd  in  REG_AW  ID/EX destination
- mem_regwrite  in  1  EX/MEM instruction writes a register
- mem_memread  in  1  EX/MEM instruction is a load
- mem_rd  in  REG_AW  EX/MEM destination
- pc_write  out  1  1 = PC may update
- ifid_write  out  1  1 = IF/ID may load
- id_bubble  out  1  1 = zero ID/EX control fields
- pc_src  out  1  0 = select branch target, 1 = select PC+4
- if_flush  out  1  squash the IF/ID instruction
- br_count  out  CNT_W  branches resolved
- br_taken  out  CNT_W  branches taken
- br_stall  out  CNT_W  cycles stalled on branch hazards

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - state=RUN, cnt=0, all counters 0.
  - Outputs during reset: pc_write=1, ifid_write=1, id_bubble=0, pc_src=1, if_flush=0.
- Dependency check:
  - A source matches a producer when the addresses are equal, the producer's regwrite=1, and rd!=0.
  - Required stalls n = max over rs1/rs2:
    - ex load match: 2
    - ex ALU match: 1
    - mem load match: 1
    - mem ALU match: 0 (EX/MEM forwards into ID)
    - otherwise: 0
- States: RUN, STALL.
- RUN:
  - branch_active = id_valid & id_branch.
  - If branch_active and n>0:
    - Same cycle: pc_write=0, ifid_write=0, id_bubble=1, pc_src=1, if_flush=0.
    - cnt<=n-1; next=STALL if n==2, else RUN.
  - If branch_active and n==0 (resolve cycle):
    - id_eq=1: pc_src=0, if_flush=1.
    - id_eq=0: pc_src=1, if_flush=0.
    - br_count increments; br_taken increments on id_eq=1.
  - Otherwise: pass-through defaults (pc_write=1, ifid_write=1, id_bubble=0, pc_src=1, if_flush=0).
- STALL:
  - Outputs: pc_write=0, ifid_write=0, id_bubble=1, pc_src=1, if_flush=0.
  - cnt decrements; when cnt==0 at the edge, next=RUN.
  - No hazard re-evaluation and no resolution in STALL.
- br_stall increments on every cycle with pc_write=0.
- Stall latency: load-use branch = 2 stall cycles, then resolve on the 3rd cycle. ALU-in-EX = 1 stall, then resolve.
- if_flush and a stall are never asserted in the same cycle.
- id_eq is ignored except in the resolve cycle.
- id_valid=0 or id_branch=0: no stall, no count, regardless of rs matches.
- Counters saturate at all-ones; no wrap.
- rst mid-STALL: FSM returns to RUN next edge, stall released, counters cleared.
- Back-to-back branches: each is resolved independently. A branch arriving right after a taken branch is flushed (id_valid=0) and not counted.

Decomposition:
- Package branch_ctrl_pkg:
  - typedef enum {RUN, STALL} br_state_t
  - localparams STALL_EX_LOAD=2, STALL_EX_ALU=1, STALL_MEM_LOAD=1
- Sub-module branch_dep_check: combinational n calculation from rs/rd/regwrite/memread inputs.

Test Plan:
- Reset held 3 cycles with id_branch=1 -> pc_write=1, pc_src=1, if_flush=0, all counters 0.
- Branch rs1=5, rs2=6, no producers, id_eq=1 -> same cycle pc_src=0, if_flush=1; br_count=1, br_taken=1.
- Branch rs1=5; ex_memread=1, ex_regwrite=1, ex_rd=5 -> 2 cycles with pc_write=0 and id_bubble=1, then resolve; br_stall=2.
- Branch rs2=7; ex_regwrite=1, ex_rd=7, memread=0 -> 1 stall cycle, then resolve with id_eq=0 -> pc_src=1, br_taken unchanged.
- Branch rs1=0; ex_regwrite=1, ex_rd=0 -> no stall.
- Same branch with id_valid=0 -> no stall, no count.
- rst during the first load-use stall cycle -> next cycle pc_write=1, state RUN, counters 0.
- Force br_count=all-ones, then resolve a branch -> value holds at all-ones.
